// File: rtl/pbs_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pbs_pkg: shared widths, move power table, LFSR taps and strobe priority
// Rev 1.0
// ---------------------------------------------------------------------------
package pbs_pkg;

   localparam int HP_W    = 8;
   localparam int STAT_W  = 8;
   localparam int PROD_W  = 2 * STAT_W;
   localparam int NUM_STB = 6;

   // Strobe bit positions; a higher index wins when several are high.
   localparam int STB_LD_PM    = 0;
   localparam int STB_LD_AM    = 1;
   localparam int STB_CALC_PH  = 2;
   localparam int STB_CALC_AH  = 3;
   localparam int STB_APPLY_AD = 4;
   localparam int STB_APPLY_PD = 5;

   // x^8 + x^6 + x^5 + x^4 + 1, shifting left: feedback from bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   localparam logic [3:0][STAT_W-1:0] MOVE_POWER = {8'd20, 8'd80, 8'd60, 8'd40};

   function automatic logic [NUM_STB-1:0] stb_priority(input logic [NUM_STB-1:0] raw);
      stb_priority = '0;
      for (int i = 0; i < NUM_STB; i++) begin
         if (raw[i]) begin
            stb_priority    = '0;
            stb_priority[i] = 1'b1;
         end
      end
   endfunction

   function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a, input logic [HP_W-1:0] b);
      sat_sub = (a > b) ? a - b : '0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pbs_battle_datapath_mult.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pbs_shift_mult: 8x8 sequential shift-add multiplier, one iteration per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module pbs_shift_mult
   import pbs_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              abort,
   input  logic [STAT_W-1:0] mcand,
   input  logic [STAT_W-1:0] mplier,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   logic [PROD_W-1:0] mcand_q, mcand_d, prod_q, prod_d;
   logic [STAT_W-1:0] mplier_q, mplier_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              busy_q, busy_d, done_q, done_d;

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      // A fresh start outranks abort so a strobe hand-over can restart cleanly.
      if (start) begin
         mcand_d  = {{STAT_W{1'b0}}, mcand};
         mplier_d = mplier;
         prod_d   = '0;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (abort) begin
         busy_d = 1'b0;
      end else if (busy_q) begin
         if (mplier_q[0]) prod_d = prod_q + mcand_q;
         mcand_d  = {mcand_q[PROD_W-2:0], 1'b0};
         mplier_d = {1'b0, mplier_q[STAT_W-1:1]};
         cnt_d    = cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign done    = done_q;
   assign product = prod_q;

endmodule
`default_nettype wire

// File: rtl/pbs_battle_datapath.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pbs_battle_datapath: HP, move latches and damage calc behind the battle FSM
// Rev 1.0
// ---------------------------------------------------------------------------
module pbs_battle_datapath
   import pbs_pkg::*;
#(
   parameter logic [HP_W-1:0]   PLAYER_MAX_HP = 8'd100,
   parameter logic [HP_W-1:0]   AI_MAX_HP     = 8'd100,
   parameter logic [STAT_W-1:0] PLAYER_ATK    = 8'd48,
   parameter logic [STAT_W-1:0] AI_ATK        = 8'd40,
   parameter logic [STAT_W-1:0] PLAYER_DEF    = 8'd6,
   parameter logic [STAT_W-1:0] AI_DEF        = 8'd5,
   parameter logic [7:0]        LFSR_SEED     = 8'hA5
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [1:0]      move_sel,
   input  logic            ld_pm,
   input  logic            calc_ph,
   input  logic            apply_ad,
   input  logic            ld_am,
   input  logic            calc_ah,
   input  logic            apply_pd,
   output logic            hp_is_zero,
   output logic            calc_done,
   output logic [HP_W-1:0] player_hp,
   output logic [HP_W-1:0] ai_hp,
   output logic [HP_W-1:0] last_damage,
   output logic            proto_err
);

   logic [NUM_STB-1:0] stb_raw, stb_sel, stb_edge, stb_prev_q;
   logic [7:0]         lfsr_q, lfsr_d;
   logic [1:0]         player_move_q, player_move_d, ai_move_q, ai_move_d;
   logic [HP_W-1:0]    player_hp_q, player_hp_d, ai_hp_q, ai_hp_d;
   logic [HP_W-1:0]    last_damage_q, last_damage_d;
   logic               calc_side_q, calc_side_d;
   logic               calc_done_q, calc_done_d, proto_err_q, proto_err_d;
   logic               multi_stb, calc_hold, mult_start, mult_abort, mult_done;
   logic [STAT_W-1:0]  mult_a, mult_b, dmg_raw, dmg_def, dmg;
   logic [PROD_W-1:0]  mult_prod;
   logic               unused_prod_lo;

   assign stb_raw   = {apply_pd, apply_ad, calc_ah, calc_ph, ld_am, ld_pm};
   assign stb_sel   = stb_priority(stb_raw);
   assign stb_edge  = stb_sel & ~stb_prev_q;
   assign multi_stb = |(stb_raw & (stb_raw - NUM_STB'(1)));

   // calc_side_q: 0 = player attacking, 1 = AI attacking
   assign calc_hold  = calc_side_q ? stb_sel[STB_CALC_AH] : stb_sel[STB_CALC_PH];
   assign mult_start = stb_edge[STB_CALC_PH] | stb_edge[STB_CALC_AH];
   assign mult_abort = ~calc_hold;
   assign mult_a     = stb_edge[STB_CALC_AH] ? AI_ATK : PLAYER_ATK;
   assign mult_b     = MOVE_POWER[stb_edge[STB_CALC_AH] ? ai_move_q : player_move_q];

   pbs_shift_mult u_mult (
      .clk     (clk),
      .resetn  (resetn),
      .start   (mult_start),
      .abort   (mult_abort),
      .mcand   (mult_a),
      .mplier  (mult_b),
      .done    (mult_done),
      .product (mult_prod)
   );

   // Product is scaled by 1/16; anything past 8 bits saturates.
   assign dmg_raw        = (|mult_prod[15:12]) ? 8'hFF : mult_prod[11:4];
   assign dmg_def        = calc_side_q ? PLAYER_DEF : AI_DEF;
   assign dmg            = (dmg_raw > dmg_def) ? dmg_raw - dmg_def : 8'd1;
   assign unused_prod_lo = ^mult_prod[3:0];

   always_comb begin
      lfsr_d        = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
      player_move_d = player_move_q;
      ai_move_d     = ai_move_q;
      player_hp_d   = player_hp_q;
      ai_hp_d       = ai_hp_q;
      last_damage_d = last_damage_q;
      proto_err_d   = proto_err_q | multi_stb;
      calc_side_d   = mult_start ? stb_edge[STB_CALC_AH] : calc_side_q;
      calc_done_d   = calc_hold & (calc_done_q | mult_done);
      if (stb_sel[STB_LD_PM])    player_move_d = move_sel;
      if (stb_edge[STB_LD_AM])   ai_move_d     = lfsr_q[1:0];
      if (calc_hold & mult_done) last_damage_d = dmg;
      if (stb_edge[STB_APPLY_AD]) ai_hp_d      = sat_sub(ai_hp_q, last_damage_q);
      if (stb_edge[STB_APPLY_PD]) player_hp_d  = sat_sub(player_hp_q, last_damage_q);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         stb_prev_q    <= '0;
         lfsr_q        <= LFSR_SEED;
         player_move_q <= '0;
         ai_move_q     <= '0;
         player_hp_q   <= PLAYER_MAX_HP;
         ai_hp_q       <= AI_MAX_HP;
         last_damage_q <= '0;
         calc_side_q   <= 1'b0;
         calc_done_q   <= 1'b0;
         proto_err_q   <= 1'b0;
      end else begin
         stb_prev_q    <= stb_raw;
         lfsr_q        <= lfsr_d;
         player_move_q <= player_move_d;
         ai_move_q     <= ai_move_d;
         player_hp_q   <= player_hp_d;
         ai_hp_q       <= ai_hp_d;
         last_damage_q <= last_damage_d;
         calc_side_q   <= calc_side_d;
         calc_done_q   <= calc_done_d;
         proto_err_q   <= proto_err_d;
      end
   end

   assign hp_is_zero  = (apply_ad & (ai_hp_q == '0)) | (apply_pd & (player_hp_q == '0));
   assign calc_done   = calc_done_q;
   assign player_hp   = player_hp_q;
   assign ai_hp       = ai_hp_q;
   assign last_damage = last_damage_q;
   assign proto_err   = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pbs_battle_datapath.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pbs_battle_datapath: self-checking bench for the PBS battle datapath
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pbs_battle_datapath;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [1:0] move_sel = 2'd0;
   logic       ld_pm = 1'b0, calc_ph = 1'b0, apply_ad = 1'b0;
   logic       ld_am = 1'b0, calc_ah = 1'b0, apply_pd = 1'b0;
   logic       hp_is_zero, calc_done, proto_err;
   logic [7:0] player_hp, ai_hp, last_damage;

   int checks = 0;
   int failures = 0;

   logic [7:0] sb_q[$];
   logic [7:0] m_lfsr;
   logic [7:0] m_player_hp, m_ai_hp, m_dmg;
   logic [1:0] m_ai_move;

   typedef struct {
      logic [1:0] move;
      logic [7:0] exp_dmg;
      bit         do_apply;
      logic [7:0] exp_ai_hp;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   pbs_battle_datapath dut (
      .clk         (clk),
      .resetn      (resetn),
      .move_sel    (move_sel),
      .ld_pm       (ld_pm),
      .calc_ph     (calc_ph),
      .apply_ad    (apply_ad),
      .ld_am       (ld_am),
      .calc_ah     (calc_ah),
      .apply_pd    (apply_pd),
      .hp_is_zero  (hp_is_zero),
      .calc_done   (calc_done),
      .player_hp   (player_hp),
      .ai_hp       (ai_hp),
      .last_damage (last_damage),
      .proto_err   (proto_err)
   );

   always @(posedge clk) begin
      if (!resetn) m_lfsr <= 8'hA5;
      else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? a - b : 8'd0;
   endfunction

   function automatic logic [7:0] exp_damage(input int atk, input logic [1:0] mv, input int def);
      int pw, p, raw;
      case (mv)
         2'd0: pw = 40;
         2'd1: pw = 60;
         2'd2: pw = 80;
         default: pw = 20;
      endcase
      p   = atk * pw;
      raw = (p >= 4096) ? 255 : (p / 16) % 256;
      return (raw > def) ? 8'(raw - def) : 8'd1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_vals();
      check("rst_player_hp", player_hp, 100);
      check("rst_ai_hp", ai_hp, 100);
      check("rst_last_damage", last_damage, 0);
      check("rst_calc_done", calc_done, 0);
      check("rst_proto_err", proto_err, 0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      {ld_pm, calc_ph, apply_ad, ld_am, calc_ah, apply_pd} = '0;
      move_sel = 2'd0;
      tick();
      tick();
      resetn      = 1'b1;
      m_player_hp = 8'd100;
      m_ai_hp     = 8'd100;
      m_dmg       = 8'd0;
      sb_q.delete();
      check_reset_vals();
   endtask

   task automatic load_player(input logic [1:0] mv);
      ld_pm    = 1'b1;
      move_sel = ~mv;
      tick();
      move_sel = mv;
      tick();
      ld_pm = 1'b0;
      tick();
   endtask

   task automatic load_ai();
      m_ai_move = m_lfsr[1:0];
      ld_am     = 1'b1;
      tick();
      tick();
      ld_am = 1'b0;
      tick();
   endtask

   task automatic calc_full(input bit ai_side, input logic [7:0] exp);
      int k;
      sb_q.push_back(exp);
      if (ai_side) calc_ah = 1'b1;
      else         calc_ph = 1'b1;
      k = 0;
      do begin
         tick();
         k++;
      end while (calc_done !== 1'b1 && k < 20);
      check("calc_latency", k, 10);
      if (calc_done === 1'b1 && sb_q.size() != 0) begin
         m_dmg = sb_q.pop_front();
         check("calc_dmg", last_damage, m_dmg);
      end else begin
         sb_q.delete();
      end
      tick();
      check("calc_done_held", calc_done, 1);
      calc_ph = 1'b0;
      calc_ah = 1'b0;
      tick();
      check("calc_done_clear", calc_done, 0);
   endtask

   task automatic abort_calc(input int hold);
      calc_ph = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         check("abort_no_done", calc_done, 0);
      end
      calc_ph = 1'b0;
      repeat (4) tick();
      check("abort_done_low", calc_done, 0);
      check("abort_dmg_kept", last_damage, m_dmg);
   endtask

   task automatic apply(input bit to_player);
      if (to_player) begin
         apply_pd    = 1'b1;
         m_player_hp = sat_sub(m_player_hp, m_dmg);
      end else begin
         apply_ad = 1'b1;
         m_ai_hp  = sat_sub(m_ai_hp, m_dmg);
      end
      tick();
      check("apply_player_hp", player_hp, m_player_hp);
      check("apply_ai_hp", ai_hp, m_ai_hp);
      check("apply_hp_is_zero", hp_is_zero, to_player ? (m_player_hp == 0) : (m_ai_hp == 0));
      tick();
      check("apply_once_player", player_hp, m_player_hp);
      check("apply_once_ai", ai_hp, m_ai_hp);
      apply_pd = 1'b0;
      apply_ad = 1'b0;
      tick();
      check("idle_hp_is_zero", hp_is_zero, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{move: 2'd3, exp_dmg: 8'd55,  do_apply: 1'b1, exp_ai_hp: 8'd45};
      vecs[1] = '{move: 2'd3, exp_dmg: 8'd55,  do_apply: 1'b1, exp_ai_hp: 8'd0};
      vecs[2] = '{move: 2'd0, exp_dmg: 8'd115, do_apply: 1'b0, exp_ai_hp: 8'd0};
      vecs[3] = '{move: 2'd1, exp_dmg: 8'd175, do_apply: 1'b0, exp_ai_hp: 8'd0};
      vecs[4] = '{move: 2'd2, exp_dmg: 8'd235, do_apply: 1'b1, exp_ai_hp: 8'd0};

      // Reset state, then an apply with no calc yet uses zero damage.
      do_reset();
      apply(1'b0);

      foreach (vecs[i]) begin
         load_player(vecs[i].move);
         calc_full(1'b0, vecs[i].exp_dmg);
         if (vecs[i].do_apply) apply(1'b0);
         check("vec_ai_hp", ai_hp, vecs[i].exp_ai_hp);
      end
      check("no_proto_err", proto_err, 0);

      // AI move straight from the seed, then from a later LFSR state.
      do_reset();
      load_ai();
      calc_full(1'b1, exp_damage(40, m_ai_move, 6));
      apply(1'b1);
      repeat (7) tick();
      load_ai();
      calc_full(1'b1, exp_damage(40, m_ai_move, 6));

      // Aborted calcs, including a drop exactly at the final edge.
      do_reset();
      load_player(2'd3);
      calc_full(1'b0, 8'd55);
      load_player(2'd2);
      abort_calc(4);
      abort_calc(9);
      calc_full(1'b0, 8'd235);

      // Two strobes at once: apply wins, calc ignored, error sticky.
      do_reset();
      load_player(2'd3);
      calc_full(1'b0, 8'd55);
      calc_ph  = 1'b1;
      apply_ad = 1'b1;
      m_ai_hp  = sat_sub(m_ai_hp, m_dmg);
      tick();
      check("proto_err_set", proto_err, 1);
      check("proto_ai_hp", ai_hp, m_ai_hp);
      repeat (11) tick();
      check("proto_no_calc", calc_done, 0);
      check("proto_ai_hp_once", ai_hp, m_ai_hp);
      check("proto_dmg_kept", last_damage, m_dmg);
      calc_ph  = 1'b0;
      apply_ad = 1'b0;
      repeat (2) tick();
      check("proto_err_sticky", proto_err, 1);

      // Reset in the middle of a multiply.
      load_player(2'd2);
      calc_ph = 1'b1;
      repeat (5) tick();
      resetn  = 1'b0;
      calc_ph = 1'b0;
      tick();
      check_reset_vals();
      resetn      = 1'b1;
      m_player_hp = 8'd100;
      m_ai_hp     = 8'd100;
      m_dmg       = 8'd0;
      repeat (12) tick();
      check("post_rst_calc_done", calc_done, 0);
      check("post_rst_dmg", last_damage, 0);
      calc_full(1'b0, 8'd115);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
